// File: rtl/ex_mem_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ex_mem_if                                                  |
// | Description : Signal bundle between the ALU/decode side and the EX->MEM |
// |               pipeline stage.                                            |
// |               The master drives the instruction fields (stall, flush,    |
// |               in_*, alu_*, branch_*, mem_*, store_data, rd, reg_write).  |
// |               The slave returns the registered EX/MEM fields (out_*),    |
// |               the PC redirect (redirect_valid, redirect_pc) and the      |
// |               sticky error flag.                                         |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface ex_mem_if #(
    parameter int XLEN = 32
);
    // Upstream -> stage
    logic            stall;
    logic            flush;
    logic            in_valid;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] alu_out;
    logic            alu_zero;
    logic            alu_error;
    logic [2:0]      branch_kind;
    logic            is_jalr;
    logic [XLEN-1:0] branch_target;
    logic [1:0]      mem_op;
    logic [1:0]      mem_size;
    logic [XLEN-1:0] store_data;
    logic [4:0]      rd;
    logic            reg_write;

    // Stage -> downstream / fetch
    logic            out_valid;
    logic [XLEN-1:0] out_result;
    logic [XLEN-1:0] out_addr;
    logic [3:0]      out_byte_en;
    logic [XLEN-1:0] out_wdata;
    logic            out_mem_read;
    logic            out_mem_write;
    logic [4:0]      out_rd;
    logic            out_reg_write;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            error;

    modport master (
        output stall, flush, in_valid, in_pc, alu_out, alu_zero, alu_error,
               branch_kind, is_jalr, branch_target, mem_op, mem_size,
               store_data, rd, reg_write,
        input  out_valid, out_result, out_addr, out_byte_en, out_wdata,
               out_mem_read, out_mem_write, out_rd, out_reg_write,
               redirect_valid, redirect_pc, error
    );

    modport slave (
        input  stall, flush, in_valid, in_pc, alu_out, alu_zero, alu_error,
               branch_kind, is_jalr, branch_target, mem_op, mem_size,
               store_data, rd, reg_write,
        output out_valid, out_result, out_addr, out_byte_en, out_wdata,
               out_mem_read, out_mem_write, out_rd, out_reg_write,
               redirect_valid, redirect_pc, error
    );
endinterface
`default_nettype wire

// File: rtl/ex_mem_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ex_mem_stage                                               |
// | Description : EX->MEM pipeline stage. Resolves branches/jumps from the   |
// |               ALU result, forms word-aligned load/store address, lane    |
// |               enables and lane-shifted store data, registers everything  |
// |               into the EX/MEM register, pulses a PC redirect for taken   |
// |               control flow and drops the wrong-path shadow slots.        |
// | Ports       : clk, reset (sync, active-high)                             |
// |               bus : ex_mem_if.slave (instruction in, EX/MEM out,         |
// |                     redirect_valid/redirect_pc, sticky error)            |
// | Parameters  : SHADOW - input slots dropped after a taken redirect (0..3) |
// |               XLEN   - data/address width, must be 32                    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module ex_mem_stage #(
    parameter int SHADOW = 2,
    parameter int XLEN   = 32
) (
    input  wire logic clk,
    input  wire logic reset,
    ex_mem_if.slave   bus
);

    // branch_kind encoding
    localparam logic [2:0] c_BR_NONE = 3'd0;
    localparam logic [2:0] c_BR_EQ   = 3'd1;
    localparam logic [2:0] c_BR_NE   = 3'd2;
    localparam logic [2:0] c_BR_LT   = 3'd3;
    localparam logic [2:0] c_BR_GE   = 3'd4;
    localparam logic [2:0] c_BR_LTU  = 3'd5;
    localparam logic [2:0] c_BR_GEU  = 3'd6;
    localparam logic [2:0] c_BR_JUMP = 3'd7;

    // mem_op / mem_size encoding
    localparam logic [1:0] c_OP_NONE  = 2'd0;
    localparam logic [1:0] c_OP_LOAD  = 2'd1;
    localparam logic [1:0] c_OP_STORE = 2'd2;
    localparam logic [1:0] c_OP_RSVD  = 2'd3;
    localparam logic [1:0] c_SZ_BYTE  = 2'd0;
    localparam logic [1:0] c_SZ_HALF  = 2'd1;
    localparam logic [1:0] c_SZ_WORD  = 2'd2;
    localparam logic [1:0] c_SZ_RSVD  = 2'd3;

    localparam logic [1:0] c_SHADOW_LOAD = 2'(SHADOW);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic            r_out_valid;
    logic [XLEN-1:0] r_out_result;
    logic [XLEN-1:0] r_out_addr;
    logic [3:0]      r_out_byte_en;
    logic [XLEN-1:0] r_out_wdata;
    logic            r_out_mem_read;
    logic            r_out_mem_write;
    logic [4:0]      r_out_rd;
    logic            r_out_reg_write;
    logic            r_redirect_valid;
    logic [XLEN-1:0] r_redirect_pc;
    logic            r_error;
    logic [1:0]      r_shadow;

    // ------------------------------------------------------------------
    // Combinational decode of the presented instruction
    // ------------------------------------------------------------------
    logic            w_taken;
    logic [XLEN-1:0] w_target;
    logic            w_is_mem;
    logic            w_misaligned;
    logic            w_mem_err;
    logic            w_bad;
    logic            w_accept;
    logic            w_live;
    logic            w_redirect;
    logic            w_target_err;
    logic [3:0]      w_byte_en;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_result;
    logic [1:0]      w_lane;

    assign w_lane = bus.alu_out[1:0];

    // The ALU computes SUB for EQ/NE (zero flag) and SLT/SLTU for the
    // ordered compares, so bit 0 of its result is the "less than" answer.
    always_comb begin
        w_taken = 1'b0;
        case (bus.branch_kind)
            c_BR_NONE: w_taken = 1'b0;
            c_BR_EQ:   w_taken = bus.alu_zero;
            c_BR_NE:   w_taken = ~bus.alu_zero;
            c_BR_LT,
            c_BR_LTU:  w_taken = bus.alu_out[0];
            c_BR_GE,
            c_BR_GEU:  w_taken = ~bus.alu_out[0];
            c_BR_JUMP: w_taken = 1'b1;
            default:   w_taken = 1'b0;
        endcase
    end

    // JALR computes its target in the ALU; everything else uses pc+imm.
    assign w_target = (bus.branch_kind == c_BR_JUMP && bus.is_jalr)
                    ? {bus.alu_out[XLEN-1:1], 1'b0}
                    : bus.branch_target;

    assign w_is_mem     = (bus.mem_op == c_OP_LOAD) || (bus.mem_op == c_OP_STORE);
    assign w_misaligned = ((bus.mem_size == c_SZ_HALF) && w_lane[0])
                       || ((bus.mem_size == c_SZ_WORD) && (w_lane != 2'b00));
    assign w_mem_err    = (bus.mem_op == c_OP_RSVD)
                       || ((bus.mem_op != c_OP_NONE) && (bus.mem_size == c_SZ_RSVD))
                       || (w_is_mem && w_misaligned);
    assign w_bad        = w_mem_err | bus.alu_error;

    // Stall and flush are also applied through the priority chain of the
    // register block; folding them in here keeps w_accept self-describing.
    assign w_accept     = bus.in_valid & ~bus.stall & ~bus.flush & (r_shadow == 2'd0);
    assign w_live       = w_accept & ~w_bad;
    assign w_redirect   = w_live & w_taken;
    // A misaligned target is flagged but the redirect still goes out.
    assign w_target_err = w_redirect & (w_target[1:0] != 2'b00);

    always_comb begin
        w_byte_en = 4'b0000;
        if (w_is_mem) begin
            case (bus.mem_size)
                c_SZ_BYTE: w_byte_en = 4'b0001 << w_lane;
                c_SZ_HALF: w_byte_en = 4'b0011 << w_lane;
                c_SZ_WORD: w_byte_en = 4'b1111;
                default:   w_byte_en = 4'b0000;
            endcase
        end
    end

    assign w_wdata  = bus.store_data << {w_lane, 3'b000};
    // Link value wraps naturally modulo 2^XLEN.
    assign w_result = (bus.branch_kind == c_BR_JUMP) ? (bus.in_pc + XLEN'(4))
                                                     : bus.alu_out;

    // ------------------------------------------------------------------
    // EX/MEM register, redirect pulse, shadow counter, sticky error
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid      <= 1'b0;
            r_out_result     <= '0;
            r_out_addr       <= '0;
            r_out_byte_en    <= 4'b0000;
            r_out_wdata      <= '0;
            r_out_mem_read   <= 1'b0;
            r_out_mem_write  <= 1'b0;
            r_out_rd         <= 5'd0;
            r_out_reg_write  <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_error          <= 1'b0;
            r_shadow         <= 2'd0;
        end else if (bus.flush) begin
            // Trap squash: kill the stage contents but keep the error record.
            r_out_valid      <= 1'b0;
            r_out_byte_en    <= 4'b0000;
            r_out_mem_read   <= 1'b0;
            r_out_mem_write  <= 1'b0;
            r_out_reg_write  <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_shadow         <= 2'd0;
        end else if (!bus.stall) begin
            // Data fields follow the inputs every free cycle; they are
            // don't-care whenever out_valid is low. Control fields are gated.
            r_out_valid      <= w_live;
            r_out_result     <= w_result;
            r_out_addr       <= {bus.alu_out[XLEN-1:2], 2'b00};
            r_out_byte_en    <= w_live ? w_byte_en : 4'b0000;
            r_out_wdata      <= w_wdata;
            r_out_mem_read   <= w_live & (bus.mem_op == c_OP_LOAD);
            r_out_mem_write  <= w_live & (bus.mem_op == c_OP_STORE);
            r_out_rd         <= bus.rd;
            r_out_reg_write  <= w_live & bus.reg_write;
            r_redirect_valid <= w_redirect;
            if (w_redirect) begin
                r_redirect_pc <= w_target;
            end
            r_error <= r_error | (w_accept & w_bad) | w_target_err;

            // Only real (in_valid) slots consume the shadow; bubbles do not.
            if (w_redirect) begin
                r_shadow <= c_SHADOW_LOAD;
            end else if (bus.in_valid && (r_shadow != 2'd0)) begin
                r_shadow <= r_shadow - 2'd1;
            end
        end
    end

    assign bus.out_valid      = r_out_valid;
    assign bus.out_result     = r_out_result;
    assign bus.out_addr       = r_out_addr;
    assign bus.out_byte_en    = r_out_byte_en;
    assign bus.out_wdata      = r_out_wdata;
    assign bus.out_mem_read   = r_out_mem_read;
    assign bus.out_mem_write  = r_out_mem_write;
    assign bus.out_rd         = r_out_rd;
    assign bus.out_reg_write  = r_out_reg_write;
    assign bus.redirect_valid = r_redirect_valid;
    assign bus.redirect_pc    = r_redirect_pc;
    assign bus.error          = r_error;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ex_mem_stage                                            |
// | Description : Directed bench for ex_mem_stage (SHADOW=2). Inputs change  |
// |               1 time unit after the rising edge, outputs are sampled at  |
// |               the same point, each against a hand-computed value.       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_ex_mem_stage;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    ex_mem_if #(.XLEN(32)) bus ();

    ex_mem_stage #(
        .SHADOW (2),
        .XLEN   (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.stall         = 1'b0;
        bus.flush         = 1'b0;
        bus.in_valid      = 1'b0;
        bus.in_pc         = 32'h0;
        bus.alu_out       = 32'h0;
        bus.alu_zero      = 1'b0;
        bus.alu_error     = 1'b0;
        bus.branch_kind   = 3'd0;
        bus.is_jalr       = 1'b0;
        bus.branch_target = 32'h0;
        bus.mem_op        = 2'd0;
        bus.mem_size      = 2'd0;
        bus.store_data    = 32'h0;
        bus.rd            = 5'd0;
        bus.reg_write     = 1'b0;
    endtask

    // Plain ALU instruction writing rd
    task automatic alu_op(input logic [31:0] res, input logic [4:0] dst);
        idle();
        bus.in_valid  = 1'b1;
        bus.alu_out   = res;
        bus.rd        = dst;
        bus.reg_write = 1'b1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        idle();
        reset = 1'b1;

        // ---- 1: reset, then a simple ADD ----
        tick();
        tick();
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_result", bus.out_result, 32'h0);
        chk("rst_byte_en", 32'(bus.out_byte_en), 32'h0);
        chk("rst_reg_write", 32'(bus.out_reg_write), 32'h0);
        chk("rst_redirect", 32'(bus.redirect_valid), 32'h0);
        chk("rst_redirect_pc", bus.redirect_pc, 32'h0);
        chk("rst_error", 32'(bus.error), 32'h0);
        reset = 1'b0;
        alu_op(32'd7, 5'd5);
        tick();
        chk("add_valid", 32'(bus.out_valid), 32'h1);
        chk("add_result", bus.out_result, 32'd7);
        chk("add_rd", 32'(bus.out_rd), 32'd5);
        chk("add_reg_write", 32'(bus.out_reg_write), 32'h1);
        chk("add_redirect", 32'(bus.redirect_valid), 32'h0);

        // ---- 2: taken BEQ, shadow of 2 (a bubble does not consume it) ----
        idle();
        bus.in_valid      = 1'b1;
        bus.branch_kind   = 3'd1;
        bus.alu_zero      = 1'b1;
        bus.branch_target = 32'h100;
        tick();
        chk("beq_redirect", 32'(bus.redirect_valid), 32'h1);
        chk("beq_redirect_pc", bus.redirect_pc, 32'h100);
        chk("beq_valid", 32'(bus.out_valid), 32'h1);
        alu_op(32'd1, 5'd1);
        tick();
        chk("shadow1_valid", 32'(bus.out_valid), 32'h0);
        chk("shadow1_reg_write", 32'(bus.out_reg_write), 32'h0);
        chk("pulse_ends", 32'(bus.redirect_valid), 32'h0);
        idle();
        tick();
        chk("bubble_valid", 32'(bus.out_valid), 32'h0);
        alu_op(32'd2, 5'd2);
        tick();
        chk("shadow2_valid", 32'(bus.out_valid), 32'h0);
        alu_op(32'd3, 5'd3);
        tick();
        chk("post_shadow_valid", 32'(bus.out_valid), 32'h1);
        chk("post_shadow_result", bus.out_result, 32'd3);

        // ---- 3: BNE not taken, BLTU taken, BGE not taken ----
        idle();
        bus.in_valid      = 1'b1;
        bus.branch_kind   = 3'd2;
        bus.alu_zero      = 1'b1;
        bus.branch_target = 32'h180;
        tick();
        chk("bne_redirect", 32'(bus.redirect_valid), 32'h0);
        chk("bne_valid", 32'(bus.out_valid), 32'h1);
        idle();
        bus.in_valid      = 1'b1;
        bus.branch_kind   = 3'd5;
        bus.alu_out       = 32'h1;
        bus.branch_target = 32'h200;
        tick();
        chk("bltu_redirect", 32'(bus.redirect_valid), 32'h1);
        chk("bltu_redirect_pc", bus.redirect_pc, 32'h200);
        alu_op(32'd0, 5'd0);
        tick();
        tick();
        chk("bltu_shadow_valid", 32'(bus.out_valid), 32'h0);
        idle();
        bus.in_valid      = 1'b1;
        bus.branch_kind   = 3'd4;
        bus.alu_out       = 32'h1;
        bus.branch_target = 32'h280;
        tick();
        chk("bge_redirect", 32'(bus.redirect_valid), 32'h0);
        chk("bge_valid", 32'(bus.out_valid), 32'h1);

        // ---- 4: stores/loads, lanes and misalignment ----
        idle();
        bus.in_valid   = 1'b1;
        bus.mem_op     = 2'd2;
        bus.mem_size   = 2'd1;
        bus.alu_out    = 32'h1002;
        bus.store_data = 32'h0000ABCD;
        tick();
        chk("sh_valid", 32'(bus.out_valid), 32'h1);
        chk("sh_byte_en", 32'(bus.out_byte_en), 32'hC);
        chk("sh_wdata", bus.out_wdata, 32'hABCD0000);
        chk("sh_addr", bus.out_addr, 32'h1000);
        chk("sh_mem_write", 32'(bus.out_mem_write), 32'h1);
        chk("sh_mem_read", 32'(bus.out_mem_read), 32'h0);
        chk("sh_error", 32'(bus.error), 32'h0);
        idle();
        bus.in_valid  = 1'b1;
        bus.mem_op    = 2'd1;
        bus.mem_size  = 2'd0;
        bus.alu_out   = 32'h2003;
        bus.rd        = 5'd9;
        bus.reg_write = 1'b1;
        tick();
        chk("lb_byte_en", 32'(bus.out_byte_en), 32'h8);
        chk("lb_mem_read", 32'(bus.out_mem_read), 32'h1);
        chk("lb_addr", bus.out_addr, 32'h2000);
        idle();
        bus.in_valid   = 1'b1;
        bus.mem_op     = 2'd2;
        bus.mem_size   = 2'd2;
        bus.alu_out    = 32'h1001;
        bus.store_data = 32'h12345678;
        tick();
        chk("sw_mis_error", 32'(bus.error), 32'h1);
        chk("sw_mis_valid", 32'(bus.out_valid), 32'h0);
        chk("sw_mis_mem_write", 32'(bus.out_mem_write), 32'h0);
        chk("sw_mis_byte_en", 32'(bus.out_byte_en), 32'h0);
        idle();
        tick();
        chk("error_sticky", 32'(bus.error), 32'h1);

        // ---- 5: JALR, then a 3-cycle stall freezing everything ----
        idle();
        bus.in_valid      = 1'b1;
        bus.branch_kind   = 3'd7;
        bus.is_jalr       = 1'b1;
        bus.in_pc         = 32'h200;
        bus.alu_out       = 32'h305;
        bus.branch_target = 32'h999;
        bus.rd            = 5'd1;
        bus.reg_write     = 1'b1;
        tick();
        chk("jalr_redirect", 32'(bus.redirect_valid), 32'h1);
        chk("jalr_redirect_pc", bus.redirect_pc, 32'h304);
        chk("jalr_result", bus.out_result, 32'h204);
        alu_op(32'h55, 5'd6);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_redirect", 32'(bus.redirect_valid), 32'h1);
            chk("stall_result", bus.out_result, 32'h204);
            chk("stall_valid", 32'(bus.out_valid), 32'h1);
        end
        idle();
        tick();
        chk("stall_pulse_end", 32'(bus.redirect_valid), 32'h0);
        chk("stall_after_valid", 32'(bus.out_valid), 32'h0);

        // Shadow survived the stall: two more real slots are dropped.
        alu_op(32'h66, 5'd6);
        tick();
        chk("jalr_shadow1", 32'(bus.out_valid), 32'h0);
        tick();
        chk("jalr_shadow2", 32'(bus.out_valid), 32'h0);

        // JAL at the top of the address space: link wraps to 0.
        idle();
        bus.in_valid      = 1'b1;
        bus.branch_kind   = 3'd7;
        bus.in_pc         = 32'hFFFFFFFC;
        bus.alu_out       = 32'h777;
        bus.branch_target = 32'h400;
        bus.rd            = 5'd1;
        bus.reg_write     = 1'b1;
        tick();
        chk("jal_wrap_result", bus.out_result, 32'h0);
        chk("jal_redirect_pc", bus.redirect_pc, 32'h400);

        // ---- 6: flush + stall + taken branch, shadow cleared ----
        idle();
        bus.flush         = 1'b1;
        bus.stall         = 1'b1;
        bus.in_valid      = 1'b1;
        bus.branch_kind   = 3'd1;
        bus.alu_zero      = 1'b1;
        bus.branch_target = 32'h500;
        tick();
        chk("flush_valid", 32'(bus.out_valid), 32'h0);
        chk("flush_redirect", 32'(bus.redirect_valid), 32'h0);
        chk("flush_reg_write", 32'(bus.out_reg_write), 32'h0);
        chk("flush_error_kept", 32'(bus.error), 32'h1);
        alu_op(32'd9, 5'd4);
        tick();
        chk("flush_shadow_clear", 32'(bus.out_valid), 32'h1);
        chk("flush_next_result", bus.out_result, 32'd9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
